mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/kakacpu_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kakacpu_pkg.sv
// Shared types for the kakacpu memory-side blocks.
// Arbiter FSM states and requester identifiers.
package kakacpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_IF,
        REQ_LS
    } requester_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One access in flight; LS has priority with a starvation guard for IF.
module mem_arbiter
    import kakacpu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

    arb_state_t state;
    arb_state_t state_nxt;
    requester_t owner;

    logic              owner_we;
    logic              flushed;
    logic              starved;
    logic              if_win;
    logic              ls_win;
    logic [1:0]        wait_cnt;
    logic [SW-1:0]     starve;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic [DATA_W-1:0] ls_resp;

    assign starved = (starve == STARVE_MAX);
    assign ls_win  = (state == IDLE) && ls_req
                   && !(starved && if_req);
    assign if_win  = (state == IDLE) && if_req && !ls_win;

    // Winner logic sees only state; keep grants low while reset is held.
    assign if_gnt = if_win && rst;
    assign ls_gnt = ls_win && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (if_win || ls_win) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (owner == REQ_IF) begin
                    if_rvalid = !flushed && !if_flush;
                end else begin
                    ls_rvalid = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ls_resp  = owner_we ? '0 : mem_rdata;
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign ls_rdata = ls_rvalid ? ls_resp : ls_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= REQ_IF;
            owner_we   <= 1'b0;
            flushed    <= 1'b0;
            wait_cnt   <= 2'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_win) begin
                        owner     <= REQ_LS;
                        owner_we  <= ls_we;
                        flushed   <= 1'b0;
                        wait_cnt  <= LAT_LAST;
                        mem_we    <= ls_we;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                    end else if (if_win) begin
                        owner     <= REQ_IF;
                        owner_we  <= 1'b0;
                        flushed   <= 1'b0;
                        wait_cnt  <= LAT_LAST;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                    if (owner == REQ_IF && if_flush) begin
                        flushed <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counts LS wins that happened while a fetch was left waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (!if_req || if_win) begin
            starve <= '0;
        end else if (ls_win && !starved) begin
            starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (ls_rvalid) begin
                ls_rdata_q <= ls_resp;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-1 and a latency-3 instance on shared inputs.
// Responses are checked against a queue filled as requests are granted.
`timescale 1ns/1ps
module tb_mem_arbiter;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;

    logic        if_gnt_a, if_rvalid_a, ls_gnt_a, ls_rvalid_a, mem_we_a;
    logic [31:0] if_rdata_a, ls_rdata_a, mem_addr_a, mem_wdata_a;
    logic [31:0] mem_rdata_a;
    logic        if_gnt_b, if_rvalid_b, ls_gnt_b, ls_rvalid_b, mem_we_b;
    logic [31:0] if_rdata_b, ls_rdata_b, mem_addr_b, mem_wdata_b;
    logic [31:0] mem_rdata_b;

    logic        sel_b;
    logic        m_if_gnt, m_ls_gnt, m_if_rvalid, m_ls_rvalid, m_mem_we;
    logic [31:0] m_if_rdata, m_ls_rdata, m_mem_addr, m_mem_wdata;

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] shadow [16];
    bit   [31:0] mem_a [16];
    bit   [31:0] mem_b [16];

    function automatic logic [31:0] base(input logic [3:0] i);
        return {16'h5A5A, 12'h000, i};
    endfunction

    mem_arbiter #(.MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt_a), .ls_rvalid(ls_rvalid_a), .ls_rdata(ls_rdata_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    mem_arbiter #(.MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt_b), .ls_rvalid(ls_rvalid_b), .ls_rdata(ls_rdata_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memories store data XOR-ed with a per-word pattern so unwritten words read base().
    always @(posedge clk) begin
        if (mem_we_a) mem_a[mem_addr_a[5:2]] <= mem_wdata_a ^ base(mem_addr_a[5:2]);
        if (mem_we_b) mem_b[mem_addr_b[5:2]] <= mem_wdata_b ^ base(mem_addr_b[5:2]);
    end
    assign mem_rdata_a = mem_a[mem_addr_a[5:2]] ^ base(mem_addr_a[5:2]);
    assign mem_rdata_b = mem_b[mem_addr_b[5:2]] ^ base(mem_addr_b[5:2]);

    assign m_if_gnt    = sel_b ? if_gnt_b    : if_gnt_a;
    assign m_ls_gnt    = sel_b ? ls_gnt_b    : ls_gnt_a;
    assign m_if_rvalid = sel_b ? if_rvalid_b : if_rvalid_a;
    assign m_ls_rvalid = sel_b ? ls_rvalid_b : ls_rvalid_a;
    assign m_if_rdata  = sel_b ? if_rdata_b  : if_rdata_a;
    assign m_ls_rdata  = sel_b ? ls_rdata_b  : ls_rdata_a;
    assign m_mem_we    = sel_b ? mem_we_b    : mem_we_a;
    assign m_mem_addr  = sel_b ? mem_addr_b  : mem_addr_a;
    assign m_mem_wdata = sel_b ? mem_wdata_b : mem_wdata_a;

    always @(negedge clk) begin
        if (m_if_rvalid || m_ls_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: if_rvalid=%b ls_rvalid=%b cycle=%0d, required no response",
                         m_if_rvalid, m_ls_rvalid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_ls_rvalid !== mon_e.is_ls
                    || (m_ls_rvalid ? m_ls_rdata : m_if_rdata) !== mon_e.data
                    || cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL resp: ls=%b data=%h cycle=%0d, required ls=%b data=%h cycle=%0d",
                             m_ls_rvalid, m_ls_rvalid ? m_ls_rdata : m_if_rdata, cyc,
                             mon_e.is_ls, mon_e.data, mon_e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL resp_missing: none by cycle %0d, required ls=%b data=%h at cycle %0d",
                     cyc, mon_e.is_ls, mon_e.data, mon_e.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok, output bit gi, output bit gl, output int at);
        ok = 1'b0; gi = 1'b0; gl = 1'b0; at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_if_gnt || m_ls_gnt) begin
                ok = 1'b1; gi = m_if_gnt; gl = m_ls_gnt; at = cyc;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        if_addr = 32'h40; ls_addr = 32'h44; ls_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_gnt_a, ls_gnt_a, if_gnt_b, ls_gnt_b} !== 4'b0) begin
            errors++;
            $display("FAIL reset_gnt: %b, required 0000", {if_gnt_a, ls_gnt_a, if_gnt_b, ls_gnt_b});
        end
        checks++;
        if ({if_rvalid_a, ls_rvalid_a, mem_we_a} !== 3'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rvalids/mem_we=%b, required 000", {if_rvalid_a, ls_rvalid_a, mem_we_a});
        end
        checks++;
        if ({mem_addr_a, mem_wdata_a, if_rdata_a, ls_rdata_a} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h ls_rdata=%h, required all 0",
                     mem_addr_a, mem_wdata_a, if_rdata_a, ls_rdata_a);
        end
        tick();
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        tick();
    endtask

    task automatic test_read(input logic [31:0] addr);
        bit ok, gi, gl; int t, t2;
        tick();
        if_addr = addr; if_req = 1'b1;
        wait_gnt(ok, gi, gl, t);
        checks++;
        if (!(ok && gi && !gl)) begin
            errors++;
            $display("FAIL read_gnt: ok=%b if=%b ls=%b, required if grant only", ok, gi, gl);
        end
        exp_q.push_back('{1'b0, shadow[addr[5:2]], t + lat + 1});
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            checks++;
            if (m_if_gnt || m_ls_gnt) begin
                errors++;
                $display("FAIL read_busy_gnt: grant at T+%0d, required none before T+%0d", k, lat + 2);
            end
            if (k == 1) begin
                checks++;
                if (m_mem_addr !== addr || m_mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_mem_addr: addr=%h we=%b, required addr=%h we=0", m_mem_addr, m_mem_we, addr);
                end
            end
        end
        @(negedge clk);
        t2 = cyc;
        checks++;
        if (m_if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL read_regrant: if_gnt=%b at T+%0d, required 1", m_if_gnt, lat + 2);
        end
        exp_q.push_back('{1'b0, shadow[addr[5:2]], t2 + lat + 1});
        tick();
        if_req = 1'b0;
        repeat (lat + 2) @(negedge clk);
        checks++;
        if (m_if_rvalid !== 1'b0 || m_if_rdata !== shadow[addr[5:2]]) begin
            errors++;
            $display("FAIL rdata_hold: rvalid=%b rdata=%h, required rvalid=0 rdata=%h",
                     m_if_rvalid, m_if_rdata, shadow[addr[5:2]]);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        bit ok, gi, gl; int t;
        tick();
        if_addr = 32'h10; if_req = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF;
        wait_gnt(ok, gi, gl, t);
        checks++;
        if (!(ok && gl && !gi)) begin
            errors++;
            $display("FAIL simul_first: ok=%b if=%b ls=%b, required ls grant only", ok, gi, gl);
        end
        shadow[8] = 32'hDEAD_BEEF;
        exp_q.push_back('{1'b1, 32'h0, t + 2});
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk);
        checks++;
        if (m_mem_we !== 1'b1 || m_mem_addr !== 32'h20 || m_mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL simul_write: we=%b addr=%h wdata=%h, required 1 00000020 deadbeef",
                     m_mem_we, m_mem_addr, m_mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (m_mem_we !== 1'b0 || m_if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL simul_we_pulse: we=%b if_gnt=%b, required 0 0", m_mem_we, m_if_gnt);
        end
        @(negedge clk);
        checks++;
        if (m_if_gnt !== 1'b1 || m_ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL simul_if_next: if_gnt=%b ls_gnt=%b, required 1 0", m_if_gnt, m_ls_gnt);
        end
        exp_q.push_back('{1'b0, shadow[4], cyc + 2});
        tick();
        if_addr = 32'h20;
        wait_gnt(ok, gi, gl, t);
        checks++;
        if (!(ok && gi)) begin
            errors++;
            $display("FAIL simul_readback_gnt: ok=%b if=%b, required 1 1", ok, gi);
        end
        exp_q.push_back('{1'b0, shadow[8], t + 2});
        tick();
        if_req = 1'b0;
        drain();
    endtask

    task automatic test_starvation();
        bit ok, gi, gl, want_ls; int t, prev;
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        if_addr = 32'h10; ls_addr = 32'h30; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        prev = -1;
        for (int g = 0; g < 10; g++) begin
            want_ls = (g % 5) != 4;
            wait_gnt(ok, gi, gl, t);
            checks++;
            if (!(ok && gl == want_ls && gi == !want_ls)) begin
                errors++;
                $display("FAIL starve_order: grant %0d ok=%b if=%b ls=%b, required ls=%b",
                         g, ok, gi, gl, want_ls);
            end
            if (prev >= 0) begin
                checks++;
                if (t != prev + 3) begin
                    errors++;
                    $display("FAIL starve_spacing: grant %0d at %0d, required %0d", g, t, prev + 3);
                end
            end
            prev = t;
            exp_q.push_back('{want_ls, want_ls ? shadow[12] : shadow[4], t + 2});
        end
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        drain();
    endtask

    task automatic test_flush();
        bit ok, gi, gl; int t, t2;
        tick();
        if_addr = 32'h14; if_req = 1'b1;
        wait_gnt(ok, gi, gl, t);
        tick();
        if_req = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_req = 1'b1;
        tick();
        if_flush = 1'b1;
        wait_gnt(ok, gi, gl, t2);
        checks++;
        if (!(ok && gi) || t2 != t + 3) begin
            errors++;
            $display("FAIL flush_regrant: ok=%b if=%b at %0d, required if grant at %0d", ok, gi, t2, t + 3);
        end
        exp_q.push_back('{1'b0, shadow[5], t2 + 2});
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        drain();
        tick();
        ls_addr = 32'h30; ls_we = 1'b0; ls_req = 1'b1;
        wait_gnt(ok, gi, gl, t);
        checks++;
        if (!(ok && gl)) begin
            errors++;
            $display("FAIL flush_ls_gnt: ok=%b ls=%b, required 1 1", ok, gl);
        end
        exp_q.push_back('{1'b1, shadow[12], t + 2});
        tick();
        ls_req = 1'b0; if_flush = 1'b1;
        tick();
        tick();
        if_flush = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        bit ok, gi, gl; int t, t2;
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h24; ls_wdata = 32'h1234_5678;
        wait_gnt(ok, gi, gl, t);
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        #1;
        checks++;
        if (m_mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_we: mem_we=%b, required 1", m_mem_we);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (m_mem_we !== 1'b0 || m_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: mem_we=%b addr=%h, required 0 0", m_mem_we, m_mem_addr);
        end
        tick();
        tick();
        rst = 1'b1; ls_req = 1'b1; ls_addr = 32'h24;
        wait_gnt(ok, gi, gl, t2);
        checks++;
        if (!(ok && gl) || t2 != t + 3) begin
            errors++;
            $display("FAIL rstmid_first_gnt: ok=%b ls=%b at %0d, required ls grant at %0d", ok, gl, t2, t + 3);
        end
        exp_q.push_back('{1'b1, shadow[9], t2 + 2});
        tick();
        ls_req = 1'b0;
        drain();
    endtask

    task automatic test_latency3();
        tick();
        rst = 1'b0;
        sel_b = 1'b1; lat = 3;
        tick();
        rst = 1'b1;
        test_read(32'h18);
    endtask

    initial begin
        checks = 0; errors = 0; sel_b = 1'b0; lat = 1;
        if_flush = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = base(4'(i));
        test_reset();
        test_read(32'h10);
        test_simultaneous();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_latency3();
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
